press_classifier: RTL and testbench
===================================

# press_classifier

Downstream consumer of the spirometer front-panel edge detector: takes the registered one-tick press pulse it produces and classifies each gesture as a single or double click. After each classified event it applies a lockout period, then reports a one-`iclk` command strobe to the measurement control logic. It runs on the same `icle` tick as the edge detector, so both stages advance in lockstep.

## Interface
- `WINDOW`, default 250: `icle` ticks after the first pulse during which a second pulse makes a double click; legal range 2..65535.
- `LOCKOUT`, default 50: `icle` ticks after each classified event during which pulses are ignored; legal range 1..65535.
- `iclk` input, 1 bit: system clock.
- `ireset` input, 1 bit: reset, synchronous, active-high, on clock `iclk`.
- `icle` input, 1 bit: tick enable, shared with the edge detector.
- `ipulso` input, 1 bit: press pulse from the edge detector, held for one `icle` period; sampled only in cycles with `icle`=1.
- `osimple` output, 1 bit: single-click strobe, one `iclk` cycle.
- `odoble` output, 1 bit: double-click strobe, one `iclk` cycle.
- `obusy` output, 1 bit: high whenever the state is not IDLE.
- `ototal` output, 8 bits: count of classified events (see Configuration).

## Operation
- The state machine has three states: IDLE, WAIT2 and LOCK. A 16-bit tick counter `cnt` supports it.
- The state machine and `cnt` change only on edges with `icle`=1. With `icle`=0 everything holds, except that the strobes still self-clear.
- IDLE: if `ipulso`=1, go to WAIT2 and set `cnt`=0. Otherwise stay.
- WAIT2:
  - If `ipulso`=1, register `odoble`=1, go to LOCK and set `cnt`=0.
  - Otherwise, if `cnt`==WINDOW-1, register `osimple`=1, go to LOCK and set `cnt`=0.
  - Otherwise increment `cnt`.
- LOCK: `ipulso` is ignored. If `cnt`==LOCKOUT-1, go to IDLE. Otherwise increment `cnt`.
- Simultaneous events: a pulse on the same tick that the window expires is classified as a double click. `osimple` and `odoble` are never high together.
- Every classification increments `ototal` by 1. `ototal` wraps from 255 to 0.
- Reset values: state IDLE, `cnt`=0, `osimple`=0, `odoble`=0, `obusy`=0, `ototal`=0.
- Reset in any state, including mid-WAIT2 or mid-LOCK, discards the pending gesture without emitting a strobe.

## Timing
- All outputs are registered.
- Strobes:
  - A strobe rises on the `iclk` edge where the decision is made (an edge with `icle`=1).
  - It falls on the next `iclk` edge, regardless of `icle`.
  - Its width is exactly one `iclk` cycle.
- Single-click latency: `osimple` is asserted at the WINDOW-th `icle` tick after the tick that sampled the first pulse.
- Double-click latency: `odoble` is asserted at the tick that samples the second pulse.
- Lockout: LOCK lasts exactly LOCKOUT ticks. The first tick that can start a new gesture is tick LOCKOUT+1 after the classification.
- `obusy` goes high on the same edge as the IDLE→WAIT2 transition and low on the same edge as the LOCK→IDLE transition.
- `ototal` updates on the same edge as the corresponding strobe.

## Configuration
- Macro `PRESS_TOTAL_EN`.
- Defined: `ototal` is an 8-bit wrapping event counter, behaving as described above.
- Undefined: the counter is not synthesized and `ototal` is constant 0. All other behaviour is unchanged.

## Test plan
All scenarios use WINDOW=4, LOCKOUT=2, `icle` high one cycle in every 4, and `PRESS_TOTAL_EN` defined unless stated.
- Reset: hold `ireset` for 3 cycles → `osimple`=`odoble`=`obusy`=0 and `ototal`=0. `ipulso` held at 1 with `ireset`=1 has no effect.
- Single click: pulse sampled at tick 0 → `osimple` high for one `iclk` at tick 4, `obusy` high from tick 0 to tick 6, `ototal`=1, `odoble` never asserted.
- Double click: pulses at ticks 0 and 2 → `odoble` high for one `iclk` at tick 2, no `osimple`, `ototal`=1.
- Expiry tie: pulses at ticks 0 and 4 → `odoble` at tick 4, no `osimple`.
- Lockout: single click classified at tick 4, pulse at tick 5 → ignored. A pulse at tick 7 starts a new window and yields `osimple` at tick 11, `ototal`=2. Stall `icle` low for 20 cycles inside WAIT2 → no change in state or outputs.
- Reset mid-op: `ireset` at tick 2 after a pulse at tick 0 → no strobe and `obusy`=0. Then, with `PRESS_TOTAL_EN` undefined, a double click leaves `ototal`=0.

Source files
------------

// File: rtl/press_classifier.sv
// ============================================================================
// Module   : press_classifier
// Purpose  : Classifies one-tick press pulses from the front-panel edge
//            detector as single or double clicks. After each classified
//            event a lockout period ignores further pulses. Every
//            classification produces a one-iclk command strobe.
// Ports    : iclk     - system clock
//            ireset   - synchronous, active-high reset
//            icle     - tick enable, shared with the edge detector
//            ipulso   - press pulse, sampled only when icle=1
//            osimple  - single-click strobe, one iclk cycle wide
//            odoble   - double-click strobe, one iclk cycle wide
//            obusy    - high whenever the state machine is not IDLE
//            ototal   - 8-bit wrapping count of classified events
// Config   : PRESS_TOTAL_EN - when defined, ototal counts classified
//            events. When undefined, the counter is not built and ototal
//            is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_classifier #(
  parameter int WINDOW  = 250,  // 2..65535 ticks
  parameter int LOCKOUT = 50    // 1..65535 ticks
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       icle,
  input  logic       ipulso,
  output logic       osimple,
  output logic       odoble,
  output logic       obusy,
  output logic [7:0] ototal
);

  localparam logic [15:0] WINDOW_LAST  = 16'(WINDOW - 1);
  localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        simple_next;
  logic        doble_next;

  // Next-state logic. Nothing advances without a tick; the strobe
  // defaults of zero make both strobes self-clear on the next edge.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    simple_next = 1'b0;
    doble_next  = 1'b0;
    if (icle) begin
      case (state)
        IDLE: begin
          if (ipulso) begin
            state_next = WAIT2;
            cnt_next   = 16'd0;
          end
        end
        WAIT2: begin
          // A pulse wins over window expiry on the same tick.
          if (ipulso) begin
            doble_next = 1'b1;
            state_next = LOCK;
            cnt_next   = 16'd0;
          end else if (cnt == WINDOW_LAST) begin
            simple_next = 1'b1;
            state_next  = LOCK;
            cnt_next    = 16'd0;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
        LOCK: begin
          if (cnt == LOCKOUT_LAST) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      osimple <= 1'b0;
      odoble  <= 1'b0;
      obusy   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      osimple <= simple_next;
      odoble  <= doble_next;
      // Registered from the next state so busy tracks state transitions
      // on the same edge.
      obusy   <= (state_next != IDLE);
    end
  end

`ifdef PRESS_TOTAL_EN
  always_ff @(posedge iclk) begin
    if (ireset) begin
      ototal <= 8'd0;
    end else if (simple_next || doble_next) begin
      ototal <= ototal + 8'd1;  // wraps 255 -> 0
    end
  end
`else
  assign ototal = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_press_classifier.sv
// ============================================================================
// Module   : tb_press_classifier
// Purpose  : Directed self-checking bench for press_classifier with
//            WINDOW=4, LOCKOUT=2 and icle high one cycle in every four.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_press_classifier;

  logic       iclk;
  logic       ireset;
  logic       icle;
  logic       ipulso;
  logic       osimple;
  logic       odoble;
  logic       obusy;
  logic [7:0] ototal;

  int checks = 0;
  int errors = 0;

  press_classifier #(
    .WINDOW (4),
    .LOCKOUT(2)
  ) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .icle   (icle),
    .ipulso (ipulso),
    .osimple(osimple),
    .odoble (odoble),
    .obusy  (obusy),
    .ototal (ototal)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Expected event count depends on whether the counter is built.
  function automatic logic [7:0] exp_tot(input int n);
`ifdef PRESS_TOTAL_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs n ticks. Bit t of each mask gives the pulse / expected output
  // for tick t. Strobes are checked right after the tick edge and again
  // one iclk later, where they must have cleared.
  task automatic run_seq(input string tag, input int n, input logic [15:0] p,
                         input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] b);
    for (int t = 0; t < n; t++) begin
      @(negedge iclk);
      icle   = 1'b1;
      ipulso = p[t];
      @(posedge iclk);
      #1;
      check($sformatf("%s.t%0d.simple", tag, t), {7'd0, osimple}, {7'd0, s[t]});
      check($sformatf("%s.t%0d.doble", tag, t), {7'd0, odoble}, {7'd0, d[t]});
      check($sformatf("%s.t%0d.busy", tag, t), {7'd0, obusy}, {7'd0, b[t]});
      @(negedge iclk);
      icle   = 1'b0;
      ipulso = 1'b0;
      @(posedge iclk);
      #1;
      check($sformatf("%s.t%0d.simple_fall", tag, t), {7'd0, osimple}, 8'd0);
      check($sformatf("%s.t%0d.doble_fall", tag, t), {7'd0, odoble}, 8'd0);
      check($sformatf("%s.t%0d.busy_hold", tag, t), {7'd0, obusy}, {7'd0, b[t]});
      @(posedge iclk);
      @(posedge iclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset with pulse and tick held high: must have no effect.
    ireset = 1'b1;
    icle   = 1'b1;
    ipulso = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    check("rst.simple", {7'd0, osimple}, 8'd0);
    check("rst.doble", {7'd0, odoble}, 8'd0);
    check("rst.busy", {7'd0, obusy}, 8'd0);
    check("rst.total", ototal, 8'd0);
    @(negedge iclk);
    ireset = 1'b0;
    icle   = 1'b0;
    ipulso = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    check("rst.idle_busy", {7'd0, obusy}, 8'd0);

    // Single click: strobe at tick 4, busy ticks 0..5, idle at tick 6.
    run_seq("single", 7, 16'h0001, 16'h0010, 16'h0000, 16'h003F);
    check("single.total", ototal, exp_tot(1));

    // Double click: pulses at 0 and 2.
    run_seq("double", 5, 16'h0005, 16'h0000, 16'h0004, 16'h000F);
    check("double.total", ototal, exp_tot(2));

    // Expiry tie: second pulse on the expiry tick is a double click.
    run_seq("tie", 7, 16'h0011, 16'h0000, 16'h0010, 16'h003F);
    check("tie.total", ototal, exp_tot(3));

    // Lockout: pulse at 5 ignored, pulse at 7 starts a new window.
    run_seq("lock", 14, 16'h00A1, 16'h0810, 16'h0000, 16'h1FBF);
    check("lock.total", ototal, exp_tot(5));

    // Stall inside WAIT2: 20 cycles without icle change nothing.
    run_seq("stall_a", 2, 16'h0001, 16'h0000, 16'h0000, 16'h0003);
    @(negedge iclk);
    ipulso = 1'b1;  // must be ignored without a tick
    for (int i = 0; i < 20; i++) begin
      @(posedge iclk);
      #1;
      if (i % 5 == 4) begin
        check($sformatf("stall.c%0d.busy", i), {7'd0, obusy}, 8'd1);
        check($sformatf("stall.c%0d.strobes", i), {6'd0, osimple, odoble}, 8'd0);
        check($sformatf("stall.c%0d.total", i), ototal, exp_tot(5));
      end
    end
    @(negedge iclk);
    ipulso = 1'b0;
    run_seq("stall_b", 5, 16'h0000, 16'h0004, 16'h0000, 16'h000F);
    check("stall.total", ototal, exp_tot(6));

    // Reset mid-WAIT2 discards the gesture.
    run_seq("midrst_a", 2, 16'h0001, 16'h0000, 16'h0000, 16'h0003);
    @(negedge iclk);
    ireset = 1'b1;
    icle   = 1'b1;
    ipulso = 1'b1;
    @(posedge iclk);
    #1;
    check("midrst.simple", {7'd0, osimple}, 8'd0);
    check("midrst.doble", {7'd0, odoble}, 8'd0);
    check("midrst.busy", {7'd0, obusy}, 8'd0);
    check("midrst.total", ototal, 8'd0);
    @(negedge iclk);
    ireset = 1'b0;
    icle   = 1'b0;
    ipulso = 1'b0;
    repeat (3) @(posedge iclk);
    run_seq("midrst_b", 6, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Double click after reset: count restarts from zero.
    run_seq("post", 5, 16'h0005, 16'h0000, 16'h0004, 16'h000F);
    check("post.total", ototal, exp_tot(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
